// File: rtl/jstk_pkg.sv
// Shared joystick definitions: channel bit positions and the auto-repeat state type.
package jstk_pkg;

    localparam int UP        = 0;
    localparam int DOWN      = 1;
    localparam int LEFT      = 2;
    localparam int RIGHT     = 3;
    localparam int PRESS     = 4;
    localparam int NUM_DIRS  = 4;
    localparam int NUM_CHANS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

endpackage

// File: rtl/jstk_chan.sv
// One joystick input channel: 2-flop synchronizer, counter debounce, and a
// rising-edge strobe of the debounced level.
module jstk_chan #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta_reg;
    logic          sync_out_reg;
    logic          stable_reg;
    logic          stable_d_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_meta_reg <= 1'b0;
            sync_out_reg  <= 1'b0;
            stable_reg    <= 1'b0;
            stable_d_reg  <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            sync_meta_reg <= raw;
            sync_out_reg  <= sync_meta_reg;
            stable_d_reg  <= stable_reg;
            // Any sample that agrees with the accepted level restarts the count.
            if (sync_out_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= ~stable_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = stable_reg;
    assign rise  = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/jstk_input_ctrl.sv
// Joystick front end: five debounced channels, registered one-cycle event pulses,
// and optional direction auto-repeat built only when JSTK_AUTOREPEAT_EN is defined.
module jstk_input_ctrl
    import jstk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] jstk_pos_raw,
    input  logic       jstk_press_raw,
    output logic [3:0] jstkPos,
    output logic       jstkPress,
    output logic [4:0] jstk_held
);

    logic [NUM_CHANS-1:0] raw_all;
    logic [NUM_CHANS-1:0] level_all;
    logic [NUM_CHANS-1:0] rise_all;
    logic [NUM_DIRS-1:0]  fire;
    logic [NUM_DIRS-1:0]  pos_reg;
    logic                 press_reg;

    assign raw_all = {jstk_press_raw, jstk_pos_raw};

    genvar gi;
    for (gi = 0; gi < NUM_CHANS; gi++) begin : g_chan
        jstk_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_all[gi]),
            .level(level_all[gi]),
            .rise (rise_all[gi])
        );
    end

`ifdef JSTK_AUTOREPEAT_EN
    localparam int DW = $clog2(REPEAT_DELAY + 1);
    localparam int PW = $clog2(REPEAT_PERIOD + 1);
    localparam logic [DW-1:0] DELAY_LAST  = DW'(REPEAT_DELAY - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(REPEAT_PERIOD - 1);

    for (gi = 0; gi < NUM_DIRS; gi++) begin : g_rep
        rep_state_t    state_reg, state_next;
        logic [DW-1:0] delay_cnt_reg, delay_cnt_next;
        logic [PW-1:0] period_cnt_reg, period_cnt_next;
        logic          fire_next;

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_reg      <= IDLE;
                delay_cnt_reg  <= '0;
                period_cnt_reg <= '0;
            end else begin
                state_reg      <= state_next;
                delay_cnt_reg  <= delay_cnt_next;
                period_cnt_reg <= period_cnt_next;
            end
        end

        always_comb begin
            state_next      = state_reg;
            delay_cnt_next  = delay_cnt_reg;
            period_cnt_next = period_cnt_reg;
            fire_next       = 1'b0;
            // A released direction or a disabled game stops repeating immediately.
            if (!en || !level_all[gi]) begin
                state_next      = IDLE;
                delay_cnt_next  = '0;
                period_cnt_next = '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rise_all[gi]) begin
                            state_next     = DELAY;
                            delay_cnt_next = '0;
                        end
                    end
                    DELAY: begin
                        if (delay_cnt_reg == DELAY_LAST) begin
                            fire_next       = 1'b1;
                            state_next      = REPEAT;
                            delay_cnt_next  = '0;
                            period_cnt_next = '0;
                        end else begin
                            delay_cnt_next = delay_cnt_reg + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (period_cnt_reg == PERIOD_LAST) begin
                            fire_next       = 1'b1;
                            period_cnt_next = '0;
                        end else begin
                            period_cnt_next = period_cnt_reg + 1'b1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        assign fire[gi] = fire_next;
    end
`else
    assign fire = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            pos_reg   <= en ? (rise_all[NUM_DIRS-1:0] | fire) : '0;
            press_reg <= en & rise_all[PRESS];
        end
    end

    assign jstkPos   = pos_reg & {NUM_DIRS{en}};
    assign jstkPress = press_reg & en;
    assign jstk_held = {level_all[PRESS], level_all[RIGHT], level_all[LEFT],
                        level_all[DOWN], level_all[UP]};

endmodule

// File: tb/tb_jstk_input_ctrl.sv
// Self-checking bench for jstk_input_ctrl: per-cycle comparison against a
// history-based behavioural model, plus hand-computed literal expectations.
module tb_jstk_input_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int NC = 1024;
`ifdef JSTK_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] jstk_pos_raw = 4'b0;
    logic       jstk_press_raw = 1'b0;
    logic [3:0] jstkPos;
    logic       jstkPress;
    logic [4:0] jstk_held;

    jstk_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .jstk_pos_raw  (jstk_pos_raw),
        .jstk_press_raw(jstk_press_raw),
        .jstkPos       (jstkPos),
        .jstkPress     (jstkPress),
        .jstk_held     (jstk_held)
    );

    always #5 clk = ~clk;

    // Cycle t is the interval just after rising edge t; e_* hold inputs seen at edge t.
    int       cyc = 0;
    bit [4:0] e_raw   [NC];
    bit       e_rst   [NC];
    bit       e_en    [NC];
    bit [4:0] m_sync  [NC];
    bit [4:0] m_stab  [NC];
    bit [4:0] m_pulse [NC];
    logic [4:0] d_pulse [NC];
    logic [4:0] d_held  [NC];
    int n_cmp = 0;
    int n_bad = 0;

    // A direction fires in cycle c when its stable level has been high (with en)
    // since its rise r, at r+RD, r+RD+RP, r+RD+2RP, ...
    function automatic bit fire_at(int c, int ch);
        int r;
        if (!AUTOREP || ch == 4 || c < 1) return 1'b0;
        if (!m_stab[c][ch]) return 1'b0;
        r = c;
        while (r > 0 && m_stab[r-1][ch]) r--;
        for (int j = r; j <= c; j++)
            if (!e_en[j+1]) return 1'b0;
        if (c - r < RD) return 1'b0;
        return ((c - r - RD) % RP) == 0;
    endfunction

    task automatic model_step(int t);
        bit flip;
        bit rise_prev;
        for (int ch = 0; ch < 5; ch++) begin
            m_sync[t][ch] = (e_rst[t] && e_rst[t-1]) ? e_raw[t-1][ch] : 1'b0;
            if (!e_rst[t]) begin
                m_stab[t][ch] = 1'b0;
            end else begin
                // Accept a change after D consecutive disagreeing samples with no reset between.
                flip = (t > D);
                for (int j = t - D; j <= t - 1; j++)
                    if (j >= 0 && (m_sync[j][ch] == m_stab[j][ch] || m_stab[j][ch] != m_stab[t-1][ch]))
                        flip = 1'b0;
                for (int j = t - D + 1; j <= t - 1; j++)
                    if (j >= 0 && !e_rst[j]) flip = 1'b0;
                m_stab[t][ch] = m_stab[t-1][ch] ^ flip;
            end
            rise_prev = m_stab[t-1][ch] && !(t >= 2 && m_stab[t-2][ch]);
            m_pulse[t][ch] = e_rst[t] && e_en[t] && (rise_prev || fire_at(t - 1, ch));
        end
    endtask

    always @(posedge clk) begin
        if (cyc < NC - 2) begin
            cyc = cyc + 1;
            e_raw[cyc] = {jstk_press_raw, jstk_pos_raw};
            e_rst[cyc] = rst;
            e_en[cyc]  = en;
            model_step(cyc);
        end
    end

    always @(negedge clk) begin
        logic [4:0] exp_pulse;
        if (cyc >= 1 && cyc < NC - 2) begin
            exp_pulse = m_pulse[cyc] & {5{en}};
            d_pulse[cyc] = {jstkPress, jstkPos};
            d_held[cyc]  = jstk_held;
            n_cmp++;
            if ({jstkPress, jstkPos} !== exp_pulse || jstk_held !== m_stab[cyc]) begin
                n_bad++;
                $display("FAIL cycle_%0d: pulse=%b held=%b, expected pulse=%b held=%b",
                         cyc, {jstkPress, jstkPos}, jstk_held, exp_pulse, m_stab[cyc]);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_lit(string name, int actual, int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int count_pulses(int ch, int from, int to);
        int n = 0;
        for (int t = from; t <= to; t++)
            if (d_pulse[t][ch] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        int t0;

        tick(3);
        check_lit("reset_held", int'(jstk_held), 0);
        check_lit("reset_pulses", int'({jstkPress, jstkPos}), 0);
        $display("reset: held=%b pulses=%b at cycle %0d", jstk_held, {jstkPress, jstkPos}, cyc);
        rst = 1'b1;
        en  = 1'b1;
        tick(4);

        // Clean rising edge on pos[0].
        t0 = cyc;
        jstk_pos_raw[0] = 1'b1;
        tick(10);
        check_lit("rise_pulse_at_7", int'(d_pulse[t0+7][0]), 1);
        check_lit("rise_pulse_count", count_pulses(0, t0 + 1, cyc - 1), 1);
        check_lit("held_at_6", int'(d_held[t0+6][0]), 1);
        check_lit("held_at_5", int'(d_held[t0+5][0]), 0);
        $display("rise pos0: t0=%0d pulses=%0d", t0, count_pulses(0, t0 + 1, cyc - 1));
        jstk_pos_raw[0] = 1'b0;
        tick(12);
        check_lit("fall_no_pulse", count_pulses(0, t0 + 10, cyc - 1), 0);

        // Short glitch on the button.
        t0 = cyc;
        jstk_press_raw = 1'b1;
        tick(3);
        jstk_press_raw = 1'b0;
        tick(12);
        check_lit("glitch_press_pulses", count_pulses(4, t0 + 1, cyc - 1), 0);
        check_lit("glitch_held", int'(jstk_held[4]), 0);
        $display("glitch press: t0=%0d pulses=%0d", t0, count_pulses(4, t0 + 1, cyc - 1));

        // pos[2] held, then released: auto-repeat train.
        t0 = cyc;
        jstk_pos_raw[2] = 1'b1;
        tick(51);
        jstk_pos_raw[2] = 1'b0;
        tick(15);
        check_lit("repeat_first", int'(d_pulse[t0+7][2]), 1);
        check_lit("repeat_plus20", int'(d_pulse[t0+27][2]), int'(AUTOREP));
        check_lit("repeat_plus44", int'(d_pulse[t0+51][2]), int'(AUTOREP));
        check_lit("repeat_after_release", int'(d_pulse[t0+59][2]), 0);
        check_lit("repeat_count", count_pulses(2, t0 + 1, cyc - 1), AUTOREP ? 5 : 1);
        $display("repeat pos2: t0=%0d pulses=%0d", t0, count_pulses(2, t0 + 1, cyc - 1));

        // Edge while disabled, then enable with the direction still held.
        t0 = cyc;
        en = 1'b0;
        jstk_pos_raw[1] = 1'b1;
        tick(15);
        en = 1'b1;
        tick(30);
        check_lit("en_pulses", count_pulses(1, t0 + 1, cyc - 1), 0);
        check_lit("en_held", int'(jstk_held[1]), 1);
        $display("disabled pos1: t0=%0d pulses=%0d held=%b", t0, count_pulses(1, t0 + 1, cyc - 1), jstk_held[1]);
        jstk_pos_raw[1] = 1'b0;
        tick(12);

        // One-cycle reset in the middle of a debounce.
        t0 = cyc;
        jstk_pos_raw[0] = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(12);
        check_lit("rst_no_pulse_7", int'(d_pulse[t0+7][0]), 0);
        check_lit("rst_pulse_13", int'(d_pulse[t0+13][0]), 1);
        check_lit("rst_pulse_count", count_pulses(0, t0 + 1, cyc - 1), 1);
        $display("mid-debounce reset: t0=%0d pulses=%0d", t0, count_pulses(0, t0 + 1, cyc - 1));
        jstk_pos_raw[0] = 1'b0;
        tick(12);

        // Simultaneous edges on several channels.
        t0 = cyc;
        jstk_pos_raw   = 4'b1001;
        jstk_press_raw = 1'b1;
        tick(10);
        check_lit("simul_pulses", int'(d_pulse[t0+7]), 5'b11001);
        $display("simultaneous: t0=%0d pulses=%b", t0, d_pulse[t0+7]);
        jstk_pos_raw   = 4'b0000;
        jstk_press_raw = 1'b0;
        tick(12);

        // Long hold on pos[3].
        t0 = cyc;
        jstk_pos_raw[3] = 1'b1;
        tick(100);
        jstk_pos_raw[3] = 1'b0;
        tick(12);
        check_lit("long_hold_count", count_pulses(3, t0 + 1, cyc - 1), AUTOREP ? 11 : 1);
        $display("long hold pos3: t0=%0d pulses=%0d", t0, count_pulses(3, t0 + 1, cyc - 1));

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jstk_input_ctrl.md
JSTK_INPUT_CTRL -- requirements
Module: jstk_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, 100000, number of consecutive equal synced samples needed to accept a level change (legal range >=1).
REQ-002 SHALL have parameter REPEAT_DELAY, 25000000, cycles a direction is held before the first auto-repeat pulse (legal range >=1).
REQ-003 SHALL have parameter REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses (legal range >=1).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  1  output enable from the game top level.
REQ-007 SHALL have port jstk_pos_raw  input  4  asynchronous joystick direction levels, one bit per direction.
REQ-008 SHALL have port jstk_press_raw  input  1  asynchronous joystick button level.
REQ-009 SHALL have port jstkPos  output  4  one-cycle direction event pulses, fed directly to GameManager.
REQ-010 SHALL have port jstkPress  output  1  one-cycle press event pulse, fed directly to GameManager.
REQ-011 SHALL have port jstk_held  output  5  debounced stable levels: {press, pos[3:0]}.

Function
REQ-012 SHALL pass each of the 5 raw inputs through a 2-flop synchronizer before any other logic uses it.
REQ-013 SHALL hold, per channel, a stable level and a counter. The counter clears whenever the synced input equals the stable level. Otherwise the counter increments, and when it reaches DEBOUNCE_CYCLES the stable level toggles and the counter clears.
REQ-014 SHALL register each output pulse, so that a clean raw rising edge gives a pulse exactly DEBOUNCE_CYCLES+3 cycles later, lasting exactly 1 cycle.
REQ-015 SHALL NOT produce a pulse on a falling edge of the stable level.
REQ-016 SHALL NOT change the stable level for a glitch shorter than DEBOUNCE_CYCLES synced cycles.
REQ-017 SHALL treat channels independently, so simultaneous rising edges on several channels pulse in the same cycle.
REQ-018 SHALL give each direction channel a repeat state machine: IDLE -> DELAY on rising edge pulse; DELAY -> REPEAT with a pulse after REPEAT_DELAY cycles; REPEAT pulses every REPEAT_PERIOD cycles.
REQ-019 SHALL return the repeat state machine from any state to IDLE in the same cycle the stable level falls, with no further pulses.
REQ-020 SHALL never auto-repeat the press channel.
REQ-021 SHALL size every counter as $clog2(param+1) bits, with no wrap-around before the terminal count.
REQ-022 SHALL, while en=0, force jstkPos and jstkPress to 0, hold repeat state machines in IDLE, and keep debounce and jstk_held tracking.
REQ-023 SHALL NOT emit a pulse when en rises with a channel already held; that channel waits for its next rising edge.

Reset
REQ-024 SHALL, while rst=0 at a clock edge, clear synchronizers, stable levels, all counters, jstkPos, jstkPress and jstk_held to 0, and set repeat state machines to IDLE.
REQ-025 SHALL, on reset asserted mid-debounce or mid-repeat, abort the operation with no pulse in the following cycle.
REQ-026 SHALL, on a raw input held high across reset release, pulse once after DEBOUNCE_CYCLES+3 cycles.

Configuration
REQ-027 SHALL use macro JSTK_AUTOREPEAT_EN: when defined, the repeat state machines of REQ-018/019 are built.
REQ-028 SHALL, when JSTK_AUTOREPEAT_EN is undefined, omit repeat logic entirely, so directions pulse only on rising edges and the REPEAT_* parameters are ignored.

Structure
REQ-029 SHALL place in shared package jstk_pkg: direction bit index constants (UP, DOWN, LEFT, RIGHT) and the repeat state enum type (IDLE, DELAY, REPEAT).
REQ-030 SHALL implement one channel (synchronizer + debounce + edge detection) as sub-module jstk_chan, instantiated 5 times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, macro defined unless stated)
REQ-031 SHALL check: jstk_pos_raw[0] rises at cycle 0 and holds -> jstkPos[0] high only at cycle 7, jstk_held[0]=1 from cycle 6.
REQ-032 SHALL check: a 3-cycle high glitch on jstk_press_raw -> jstkPress and jstk_held[4] stay 0.
REQ-033 SHALL check: pos[2] held 50 cycles after its first pulse -> repeat pulses at +20, +28, +36, +44; release -> no pulse after the stable level falls.
REQ-034 SHALL check: en=0 while pos[1] rises and holds, then en=1 -> zero pulses, jstk_held[1]=1.
REQ-035 SHALL check: rst=0 for 1 cycle at cycle 5 of a debounce -> no pulse at cycle 7; pulse at cycle 13 if the raw level stays high.
REQ-036 SHALL check: macro undefined, pos[3] held 100 cycles -> exactly one pulse.
